// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Write-side loader for the byte-addressed, little-endian
//             instruction memory. It accepts 32-bit words over a valid/ready
//             stream and writes each word as four consecutive bytes, least
//             significant byte first, starting at a programmable base address.
//             It tracks the byte count and flags a sticky overflow when a
//             session would run past the end of memory.
//  Ports    : clk, reset (sync, active-low)
//             start, base_addr         - session control (sampled in IDLE)
//             word_valid/data/last     - upstream word stream
//             word_ready               - word accepted this cycle
//             mem_we/addr/wdata        - byte write port to instruction memory
//             busy, done, overflow     - session status
//             bytes_written            - bytes written in current/last session
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DEPTH = 80,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          word_valid,
   input  logic [31:0]   word_data,
   input  logic          word_last,
   output logic          word_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic [AW:0]   bytes_written
);

   localparam logic [2:0] c_idle   = 3'd0;
   localparam logic [2:0] c_accept = 3'd1;
   localparam logic [2:0] c_write  = 3'd2;
   localparam logic [2:0] c_done   = 3'd3;
   localparam logic [2:0] c_error  = 3'd4;

   // Highest pointer at which a whole word still fits (ptr+3 <= DEPTH-1).
   // The pointer carries one extra bit so that it can reach DEPTH even when
   // DEPTH == 2**AW without wrapping back into range. Assumes DEPTH >= 4.
   localparam logic [AW:0] c_last_start = (AW+1)'(DEPTH - 4);

   logic [2:0]  state_q, state_d;
   logic [AW:0] ptr_q, ptr_d;
   logic [AW:0] bytes_q, bytes_d;
   logic        ovf_q, ovf_d;
   logic [31:0] word_q, word_d;
   logic        last_q, last_d;
   logic [1:0]  k_q, k_d;

   logic        w_no_room;
   logic        w_in_write;
   logic [7:0]  w_byte;

   assign w_no_room  = (ptr_q > c_last_start);
   assign w_in_write = (state_q == c_write);
   assign w_byte     = word_q[{k_q, 3'b000} +: 8];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      bytes_d = bytes_q;
      ovf_d   = ovf_q;
      word_d  = word_q;
      last_d  = last_q;
      k_d     = k_q;
      case (state_q)
         c_idle: begin
            if (start) begin
               ptr_d   = {1'b0, base_addr};
               bytes_d = '0;
               ovf_d   = 1'b0;
               state_d = c_accept;
            end
         end
         c_accept: begin
            // The room check takes priority so no word is ever taken that
            // could not be written completely.
            if (w_no_room) begin
               state_d = c_error;
            end else if (word_valid) begin
               word_d  = word_data;
               last_d  = word_last;
               k_d     = 2'd0;
               state_d = c_write;
            end
         end
         c_write: begin
            ptr_d   = ptr_q + 1'b1;
            bytes_d = bytes_q + 1'b1;
            k_d     = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = last_q ? c_done : c_accept;
            end
         end
         c_done: begin
            state_d = c_idle;
         end
         c_error: begin
            ovf_d   = 1'b1;
            state_d = c_idle;
         end
         default: begin
            state_d = c_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= c_idle;
         ptr_q   <= '0;
         bytes_q <= '0;
         ovf_q   <= 1'b0;
         word_q  <= '0;
         last_q  <= 1'b0;
         k_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         bytes_q <= bytes_d;
         ovf_q   <= ovf_d;
         word_q  <= word_d;
         last_q  <= last_d;
         k_q     <= k_d;
      end
   end

   // All outputs decode registered state only; nothing from word_* reaches
   // the memory port combinationally.
   assign word_ready    = (state_q == c_accept) && !w_no_room;
   assign mem_we        = w_in_write;
   assign mem_addr      = w_in_write ? ptr_q[AW-1:0] : '0;
   assign mem_wdata     = w_in_write ? w_byte : 8'h00;
   assign busy          = (state_q != c_idle);
   assign done          = (state_q == c_done);
   assign overflow      = ovf_q;
   assign bytes_written = bytes_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and splits each word into four byte writes, least-significant byte first.
- Writes go to consecutive byte addresses starting at a programmable base address.
- Used at boot or by the test harness to program instruction memory without file preload; tracks progress and reports overflow.

Parameters:
- DEPTH, 80, instruction memory size in bytes.
- AW, 7, byte address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a load session; sampled only in IDLE.
- base_addr  in  AW  first byte address of the session; latched on start.
- word_valid  in  1  upstream has a word.
- word_data  in  32  instruction word.
- word_last  in  1  marks final word of session; qualified by word_valid.
- word_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  AW  byte address of the write.
- mem_wdata  out  8  byte to write.
- busy  out  1  session in progress (any state other than IDLE).
- done  out  1  one-cycle pulse on successful completion.
- overflow  out  1  sticky error; session hit the end of memory.
- bytes_written  out  AW+1  bytes written in the current or last session.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state=IDLE; word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, overflow=0, bytes_written=0.
  - Reset mid-session aborts immediately; no further writes occur. Bytes already written stay in memory.
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE:
  - On start=1: ptr<=base_addr, bytes_written<=0, overflow<=0, go to ACCEPT.
  - start in any other state is ignored.
- ACCEPT:
  - If ptr > DEPTH-4, go to ERROR with word_ready=0, so no word is accepted.
  - Otherwise word_ready=1. On word_valid&&word_ready: word_q<=word_data, last_q<=word_last, k<=0, go to WRITE.
  - With word_valid=0, stay in ACCEPT indefinitely.
- WRITE, four cycles, k=0..3:
  - mem_we=1, mem_addr=ptr, mem_wdata=word_q[8k+7:8k].
  - Each cycle: ptr<=ptr+1, bytes_written<=bytes_written+1.
  - word_ready=0 throughout.
  - After k=3: go to DONE if last_q, else ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERROR: overflow<=1 and held until the next accepted start or reset; go to IDLE next cycle. done is not asserted.
- Timing:
  - start sampled at edge E0: word_ready=1 in the cycle after E0.
  - Handshake at edge H: writes occupy the 4 cycles after H.
  - Sustained throughput is 1 word per 5 cycles.
  - Last byte written at cycle H+4; done is high in cycle H+5.
- mem_we, mem_addr and mem_wdata are decoded from registered state only. No combinational path from word_* inputs to mem_* outputs.
- mem_we=0 in every state except WRITE. mem_addr and mem_wdata are don't-care when mem_we=0; drive them 0.
- Addresses never wrap. The overflow check in ACCEPT guarantees that ptr+3 <= DEPTH-1 for every write.
- base_addr need not be word aligned.
- bytes_written is held after DONE or ERROR until the next start.

Test Plan:
- Reset then start, base_addr=0, one word 0x12345678 with last=1:
  - writes (0,0x78), (1,0x56), (2,0x34), (3,0x12) on consecutive cycles.
  - done pulses once; bytes_written=4; busy falls.
- Three words 0x00000013, 0x00100093, 0x002081B3 from base 8, last on the third, word_valid held high:
  - 12 writes to addresses 8..19 in little-endian order.
  - word_ready high only 1 cycle of every 5; bytes_written=12.
- Backpressure:
  - Hold word_valid=0 for 10 cycles after start: no mem_we, word_ready stays 1.
  - Then assert word_valid: writes begin on the next cycle.
- Overflow, base_addr=72 with DEPTH=80:
  - Two words complete, writing addresses 72..79.
  - Third word is never accepted (word_ready=0); overflow=1, done=0, bytes_written=8.
  - A subsequent start clears overflow.
- Reset asserted during the second WRITE cycle:
  - mem_we=0 from the next cycle and all outputs reach reset values.
  - After reset release, a new start at base 4 writes correctly.
- start pulsed while busy: ignored; ptr and bytes_written are unaffected.
